// File: rtl/jt51_sdm_pkg.sv
// Shared constants and helpers for the JT51 pulse-density decoders.
// Width derivation, output scaling and signed saturation live here so sibling blocks agree.
package jt51_sdm_pkg;

  function automatic int cic_w(input int log2r);
    return 3 * log2r + 1;
  endfunction

  function automatic int cic_shift(input int log2r, input int width);
    return 3 * log2r - width;
  endfunction

  // Mid-scale of the sinc3 output range 0..2^(3*log2r)
  function automatic logic [63:0] cic_offset(input int log2r);
    return 64'd1 << (3 * log2r - 1);
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/jt51_cic_comb.sv
// One sinc differentiator stage: o_dat <= i_dat - previous i_dat, updated only when i_en.
// One cycle from i_en to o_dat; no flow control, the enable is the strobe.
module jt51_cic_comb #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_d;
  logic [W-1:0] r_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d <= '0;
      r_c <= '0;
    end else if (i_en) begin
      r_c <= i_dat - r_d;
      r_d <= i_dat;
    end
  end

  assign o_dat = r_c;

endmodule

// File: rtl/jt51_sdm_decim.sv
// sinc3 decimator turning a 1-bit pulse-density stream into signed PCM at cen/R.
// dout/dout_valid land 4 clk after the decimation strobe; the sink cannot stall it.
module jt51_sdm_decim
  import jt51_sdm_pkg::*;
#(
  parameter int width = 16,
  parameter int log2r = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cen,
  input  logic                    din,
  output logic signed [width-1:0] dout,
  output logic                    dout_valid
);

  localparam int         W   = cic_w(log2r);
  localparam int         SH  = cic_shift(log2r, width);
  localparam logic [W-1:0] OFS = W'(cic_offset(log2r));

  logic [W-1:0]           r_i1, r_i2, r_i3, r_x;
  logic [log2r-1:0]       r_ph;
  logic [3:0]             r_stg;
  logic [1:0]             r_warm;
  logic signed [width-1:0] r_dout;
  logic                   r_valid;

  logic                   w_s0;
  logic [W-1:0]           w_c1, w_c2, w_c3, w_diff;
  logic signed [W-1:0]    w_sh;
  logic signed [width-1:0] w_dout;

  assign w_s0 = cen && (r_ph == '1);

  // Integrators wrap modulo 2^W on purpose; the combs undo the wrap exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_i3  <= '0;
      r_x   <= '0;
      r_ph  <= '0;
      r_stg <= '0;
    end else begin
      if (cen) begin
        r_i1 <= r_i1 + W'(din);
        r_i2 <= r_i2 + r_i1;
        r_i3 <= r_i3 + r_i2;
        r_ph <= r_ph + log2r'(1);
      end
      if (w_s0) r_x <= r_i3 + r_i2;
      r_stg <= {r_stg[2:0], w_s0};
    end
  end

  jt51_cic_comb #(.W(W)) u_comb1 (.clk(clk), .rst_n(rst_n), .i_en(r_stg[0]), .i_dat(r_x),  .o_dat(w_c1));
  jt51_cic_comb #(.W(W)) u_comb2 (.clk(clk), .rst_n(rst_n), .i_en(r_stg[1]), .i_dat(w_c1), .o_dat(w_c2));
  jt51_cic_comb #(.W(W)) u_comb3 (.clk(clk), .rst_n(rst_n), .i_en(r_stg[2]), .i_dat(w_c2), .o_dat(w_c3));

  // Re-centre around zero, then +full scale (c3 = 2^(3*log2r)) clips to the max code.
  assign w_diff = w_c3 - OFS;
  assign w_sh   = $signed(w_diff) >>> SH;
  assign w_dout = width'(sat_s(64'(w_sh), width));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_warm  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (r_stg[3]) begin
        r_dout <= w_dout;
        if (r_warm == 2'd3) r_valid <= 1'b1;
        else r_warm <= r_warm + 2'd1;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;

endmodule

// File: doc/jt51_sdm_decim.md
# jt51_sdm_decim

Sigma-delta decoder: takes the 1-bit pulse-density stream that the JT51 sigma-delta DAC path produces and recovers signed PCM. It uses a 3rd-order CIC (sinc³) decimator with a fixed power-of-two ratio. It sits on the receive side of any 1-bit audio link, for example loop-back checking of the DAC or a PDM microphone/ADC input, and feeds PCM sinks at clk/R.

## Interface
- `width`, default 16: output PCM width, signed.
- `log2r`, default 6: log2 of the decimation ratio R (R = 64). Constraint: 3·log2r ≥ width.
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset. Synchronous, active-low.
- `cen`  in  1: input sample enable. `din` is consumed only on cycles with `cen`=1.
- `din`  in  1: pulse-density bit. 1 means +full scale, 0 means −full scale.
- `dout`  out  width: signed PCM sample, held between updates.
- `dout_valid`  out  1: one-cycle strobe marking a new `dout`.

## Operation
- Internal width W = 3·log2r+1. All integrator and comb registers are W bits, two's-complement, and wrap modulo 2^W. Wrap-around is intended and must not be saturated.
- Integrators advance only on `cen`=1. Each uses the previous-cycle values:
  - i1 ← i1 + din (0/1 zero-extended)
  - i2 ← i2 + i1
  - i3 ← i3 + i2
- Phase counter `ph` (log2r bits) increments on `cen`=1 and wraps R−1→0.
- Decimation strobe s0 fires on the `cen`=1 cycle where `ph`=R−1. On s0, x ← i3 after that cycle's update.
- Comb pipeline advances every clk, not gated by `cen`:
  - s1: c1 ← x − d1, d1 ← x
  - s2: c2 ← c1 − d2, d2 ← c1
  - s3: c3 ← c2 − d3, d3 ← c2
  - s4: output stage, below.
- Output stage: c3 lies in 0…2^(3·log2r).
  - v = (c3 − 2^(3·log2r−1)) >>> (3·log2r − width), arithmetic shift.
  - `dout` ← v saturated to [−2^(width−1), 2^(width−1)−1].
- Warm-up: a 2-bit counter counts decimated outputs after reset. The first 3 s4 events update `dout` but do not assert `dout_valid`. `dout_valid` pulses on every s4 from the 4th onward.
- Reset (`rst_n`=0 at a clk edge) clears everything:
  - integrators, combs, delays, `ph` and the warm-up counter go to 0
  - `dout` goes to 0 and `dout_valid` to 0
  - any in-flight s1–s4 stages are discarded
- Reset asserted mid-frame: no strobe in flight may complete afterward.

## Timing
- `dout_valid` goes high exactly 4 clk cycles after the s0 cycle, for one cycle. `dout` changes on that same edge.
- Output rate is one sample per R `cen` pulses. With `cen` tied high, that is one sample every R clk cycles.
- Minimum `cen` spacing is 1 cycle. Bursty `cen` is allowed if strobes are ≥4 clk apart. With R ≥ 4 and `cen` at most one per cycle this always holds.
- After reset release, the first `dout_valid` occurs on the 4th decimated frame: clk cycle 4R+3 after release with `cen`=1, counting the first active edge as cycle 0.
- `rst_n` has priority over `cen`.

## Structure
- Shared package `jt51_sdm_pkg` holds:
  - W derivation function (3·log2r+1)
  - shift amount and offset constant 2^(3·log2r−1)
  - saturation helper, shared with future PDM blocks
- One natural sub-module, `jt51_cic_comb`: a single differentiator stage (W-bit register plus subtractor, enable input), instantiated three times.
- Integrators, phase counter, warm-up counter and output stage stay in the top module.

## Test plan
- All-zeros `din`, `cen`=1, after reset: first `dout_valid` at cycle 4R+3 with `dout`=−32768, and every later strobe gives −32768.
- All-ones `din`, `cen`=1: after warm-up, `dout`=32767 (saturated from +32768). Internal c3 = 2^18 exactly, which checks that W-bit wrap is correct.
- Alternating 1,0,1,0 at R=64: all post-warm-up `dout`=0 exactly, and strobes are spaced exactly 64 cycles.
- `cen` asserted every 3rd clk with all-ones `din`: strobe spacing is 192 clk, values match the `cen`=1 case, and comb latency is still 4 clk.
- Loop-back with the team's 2nd-order sigma-delta DAC at width 16, fed constant +8192: post-warm-up `dout` within ±64 of 8192; a −8192 step settles within 3 output samples.
- Reset pulse 2 cycles after an s0: no `dout_valid` for that frame, `dout` reads 0, and warm-up restarts with the first valid again at 4R+3 after release.
